// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order imem requests, response queue toward decode,
// and branch/jump redirect with stale-response discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = 16;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t        q     [DEPTH];
    logic [31:0]   pc_q  [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
    logic [CW-1:0] count, outstanding;
    logic [DW-1:0] discard, discard_sum, discard_redir;
    logic [31:0]   fpc;
    logic          credit_ok, req_fire, rsp_drop, enq, deq;

    assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < CREDITS;
    assign imem_req_valid = reset_n & ~redirect_valid & credit_ok;
    assign imem_req_addr  = fpc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (redirect_valid | (discard != '0));
    assign enq      = imem_rsp_valid & ~rsp_drop;

    assign instr_valid = (count != '0);
    assign deq         = instr_valid & instr_ready;
    assign Instr       = instr_valid ? q[rd_ptr].instr : 32'h0;
    assign PC          = instr_valid ? q[rd_ptr].pc    : 32'h0;

    // Everything in flight becomes stale; a response landing this cycle is one of them.
    assign discard_sum   = discard + DW'(outstanding);
    assign discard_redir = (imem_rsp_valid && discard_sum != '0) ? discard_sum - DW'(1)
                                                                 : discard_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fpc <= RESET_PC;
        else if (redirect_valid)
            fpc <= redirect_target & ~32'h3;
        else if (req_fire)
            fpc <= fpc + 32'd4;
    end

    // Stale responses never read pc_q, so a redirect simply empties it; it then only
    // ever tags live requests, which the credit rule bounds to DEPTH.
    always_ff @(posedge clk) begin
        if (req_fire)
            pc_q[pq_wr] <= fpc;
        if (enq)
            q[wr_ptr] <= '{instr: imem_rsp_data, pc: pc_q[pq_rd]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= discard_redir;
        end else begin
            if (enq)      wr_ptr <= wr_ptr + PW'(1);
            if (deq)      rd_ptr <= rd_ptr + PW'(1);
            if (req_fire) pq_wr  <= pq_wr + PW'(1);
            if (enq)      pq_rd  <= pq_rd + PW'(1);
            count       <= count + CW'(enq) - CW'(deq);
            outstanding <= outstanding + CW'(req_fire) - CW'(enq);
            if (imem_rsp_valid && discard != '0)
                discard <= discard - DW'(1);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected {PC, Instr} entries,
// a monitor pops and compares on every decode handshake.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] Instr, PC;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    logic mem_ready = 1'b1;
    int   mem_lat = 1;
    int   n_checks = 0;
    int   n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .Instr(Instr), .PC(PC),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
    );

    always #5 clk = ~clk;
    assign imem_req_ready = mem_ready;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected decode stream
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc, mem_word(pc)});
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got PC %h, expected nothing", PC);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", PC, e.pc);
                    chk("instr_word", Instr, e.instr);
                end
            end else if (!instr_valid) begin
                chk("idle_zero", Instr | PC, 32'h0);
            end
        end
    end

    // In-order memory with programmable latency
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t       mq[$];
    logic        rst_s = 1'b0;
    logic        fire_s = 1'b0;
    logic [31:0] addr_s = 32'h0;
    int          mcyc = 0;

    always @(negedge clk) begin
        rst_s  = reset_n;
        fire_s = reset_n && imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_s) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            mcyc++;
            if (fire_s) mq.push_back('{addr_s, mcyc + mem_lat - 1});
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b0;
        mem_ready       = 1'b1;
        mem_lat         = 1;
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_pc", PC, 0);
        chk("leftover_expected", exp_q.size(), 0);
        exp_q.delete();
        nxt();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, flow, then a 5-cycle decode stall
        do_reset();
        instr_ready = 1'b1;
        for (int a = 32'h3000; a <= 32'h3018; a += 4) push_exp(a);
        @(negedge clk);
        chk("t1_req_valid_c1", imem_req_valid, 1);
        chk("t1_req_addr_c1", imem_req_addr, 32'h3000);
        chk("t1_ivalid_c1", instr_valid, 0);
        nxt(); @(negedge clk);
        chk("t1_req_addr_c2", imem_req_addr, 32'h3004);
        chk("t1_ivalid_c2", instr_valid, 0);
        nxt(); @(negedge clk);
        chk("t1_ivalid_c3", instr_valid, 1);
        chk("t1_credit_c3", imem_req_valid, 0);
        nxt(); @(negedge clk);
        chk("t1_req_valid_c4", imem_req_valid, 1);
        chk("t1_req_addr_c4", imem_req_addr, 32'h3008);
        nxt(); nxt(); nxt();
        nxt(); instr_ready = 1'b0;
        nxt(); nxt();
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_valid", instr_valid, 1);
            chk("t2_stall_pc", PC, 32'h3010);
            chk("t2_stall_no_req", imem_req_valid, 0);
            nxt();
        end
        instr_ready = 1'b1;
        nxt(); nxt(); nxt();
        nxt(); instr_ready = 1'b0;

        // Redirect with two requests in flight; low target bits ignored
        do_reset();
        mem_lat = 3;
        instr_ready = 1'b1;
        push_exp(32'h3040); push_exp(32'h3044);
        @(negedge clk); chk("t3_req_addr_c1", imem_req_addr, 32'h3000);
        nxt(); @(negedge clk); chk("t3_req_addr_c2", imem_req_addr, 32'h3004);
        nxt(); redirect_valid = 1'b1; redirect_target = 32'h0000_3043;
        @(negedge clk); chk("t3_no_req_redirect", imem_req_valid, 0);
        nxt(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_req_valid_target", imem_req_valid, 1);
        chk("t3_req_addr_target", imem_req_addr, 32'h3040);
        repeat (3) begin
            nxt(); @(negedge clk); chk("t3_stale_dropped", instr_valid, 0);
        end
        nxt(); @(negedge clk);
        chk("t3_first_valid", instr_valid, 1);
        chk("t3_first_pc", PC, 32'h3040);
        nxt();
        nxt(); instr_ready = 1'b0;

        // Redirect coinciding with a response and a dequeue
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'h3000); push_exp(32'h5000); push_exp(32'h5004);
        nxt(); nxt();
        redirect_valid = 1'b1; redirect_target = 32'h0000_5000;
        @(negedge clk);
        chk("t4_no_req_redirect", imem_req_valid, 0);
        chk("t4_deq_in_redirect", instr_valid, 1);
        nxt(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_req_addr_target", imem_req_addr, 32'h5000);
        chk("t4_ivalid_c4", instr_valid, 0);
        nxt(); @(negedge clk); chk("t4_ivalid_c5", instr_valid, 0);
        nxt(); @(negedge clk); chk("t4_target_pc", PC, 32'h5000);
        nxt();
        nxt(); instr_ready = 1'b0;

        // Memory back-pressure holds the request
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'h3000); push_exp(32'h3004); push_exp(32'h3008);
        nxt(); nxt(); nxt();
        mem_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t5_hold_valid", imem_req_valid, 1);
            chk("t5_hold_addr", imem_req_addr, 32'h3008);
            nxt();
        end
        mem_ready = 1'b1;
        @(negedge clk); chk("t5_accept_addr", imem_req_addr, 32'h3008);
        nxt(); @(negedge clk);
        chk("t5_after_accept_valid", imem_req_valid, 1);
        chk("t5_after_accept_addr", imem_req_addr, 32'h300C);
        nxt();
        nxt(); instr_ready = 1'b0;

        // Back-to-back redirects, last one wraps the address space
        do_reset();
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h0000_7000;
        push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000);
        @(negedge clk); chk("t6_no_req_c1", imem_req_valid, 0);
        nxt(); redirect_target = 32'hFFFF_FFFF;
        @(negedge clk); chk("t6_no_req_c2", imem_req_valid, 0);
        nxt(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_req_valid_top", imem_req_valid, 1);
        chk("t6_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        nxt(); @(negedge clk);
        chk("t6_req_addr_wrap", imem_req_addr, 32'h0000_0000);
        nxt(); nxt();
        nxt(); instr_ready = 1'b0;

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
